dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared data RAM port of the CPU core.
- Requester C is the CPU load/store path. Requester L is a memory loader/debug port that preloads or inspects data memory.
- Grants one transaction at a time with round-robin fairness and drives the RAM strobes, address and write data for a configurable access latency.
- Returns read data and a one-cycle done pulse to the winner; exposes a stall to the CPU.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 1, cycles the RAM strobe is held per access (legal range >=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
c_req  input  1  CPU transaction request, held until c_done
c_we  input  1  CPU: 1=store, 0=load
c_addr  input  ADDR_W  CPU address
c_wdata  input  DATA_W  CPU store data
c_rdata  output  DATA_W  CPU load data, registered
c_done  output  1  one-cycle CPU completion pulse
cpu_stall  output  1  c_req & ~c_done, combinational
l_req  input  1  loader request, held until l_done
l_we  input  1  loader: 1=write, 0=read
l_addr  input  ADDR_W  loader address
l_wdata  input  DATA_W  loader write data
l_rdata  output  DATA_W  loader read data, registered
l_done  output  1  one-cycle loader completion pulse
m_rd_en  output  1  RAM read strobe (en_fetch_data)
m_wr_en  output  1  RAM write strobe (en_store_data)
m_addr  output  ADDR_W  RAM address
m_wdata  output  DATA_W  RAM write data
m_rdata  input  DATA_W  RAM read data
busy  output  1  high in ACCESS and RESP
owner  output  1  granted requester, 0=C, 1=L; valid while busy

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0 immediately, including c_rdata and l_rdata.
  - last_owner is set to 1, so C wins the first tie.
  - An in-flight access is abandoned with no done pulse. Requesters must reissue.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sample c_req and l_req.
  - Only one asserted: grant it.
  - Both asserted: grant the requester that is not last_owner.
  - On grant: register owner, we, addr and wdata of the winner; load the latency counter with MEM_LAT-1; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - m_addr and m_wdata are driven from the latched values.
  - m_rd_en = ~we or m_wr_en = we, held for exactly MEM_LAT cycles.
  - Counter at 0 and read: capture m_rdata into the owner's rdata register on this edge.
  - Counter at 0: go to RESP and set last_owner to owner.
  - Otherwise: decrement the counter.
- RESP:
  - Strobes low.
  - Owner's done is high for this single cycle; rdata is valid.
  - Go to IDLE.
- Latency: request sampled in IDLE at cycle 0; strobe in cycles 1..MEM_LAT; done in cycle MEM_LAT+1. Back-to-back throughput is one transaction per MEM_LAT+2 cycles.
- Requester protocol:
  - The requester keeps req, we, addr and wdata stable until it samples done, then drops req on the following cycle.
  - A req still high in IDLE after done is a new transaction.
- Request dropped mid-transaction: ignored. The access completes and done still pulses (no abort).
- Register updates:
  - Writes never update c_rdata or l_rdata.
  - The non-owner's rdata is never modified.
  - rdata holds until that port's next completed read.
- Request fields changing after grant have no effect; the latched copies are used.
- Strobes are mutually exclusive, and both are low outside ACCESS.
- c_done and l_done are never high in the same cycle.

Test Plan:
- CPU read alone, MEM_LAT=1: c_req=1, c_we=0, c_addr=0x10, m_rdata=0xDEADBEEF -> m_rd_en=1 with m_addr=0x10 in cycle 1 only; c_done=1 in cycle 2; c_rdata=0xDEADBEEF; busy=1 cycles 1-2.
- Loader write: l_we=1, l_addr=0x20, l_wdata=0x12345678 -> m_wr_en=1 for one cycle with m_wdata=0x12345678; l_done in cycle 2; c_rdata and l_rdata unchanged; owner=1.
- Simultaneous requests right after reset, both held and re-requested -> C done cycle 2, L granted cycle 3 and done cycle 5, C next; strict alternation continues with no starvation.
- MEM_LAT=3 CPU read -> m_rd_en high cycles 1-3; m_rdata captured at end of cycle 3; c_done cycle 4; cpu_stall high cycles 0-3, low cycle 4.
- rst driven low during ACCESS -> all strobes, done and rdata go to 0 without a clock; no done pulse afterwards. After release, simultaneous requests grant C first.
- c_req dropped in cycle 1 of a MEM_LAT=2 write -> m_wr_en still held 2 cycles and c_done pulses in cycle 3; a following l_req is granted next.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / loader) round-robin arbiter and access sequencer for the shared data RAM port.
// One transaction at a time: strobe held MEM_LAT cycles, then a single-cycle done pulse to the winner.
//
// state  | meaning
// IDLE   | waiting for c_req / l_req, grants one and latches its fields
// ACCESS | RAM strobe asserted from latched fields for MEM_LAT cycles
// RESP   | one-cycle done pulse to the owner, owner's rdata valid
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_done,
    output logic              cpu_stall,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_done,
    output logic              m_rd_en,
    output logic              m_wr_en,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t              state, state_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic                last_owner, last_owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                c_cap, l_cap;
    logic                grant_l;

    // On a tie the requester that did not win last time gets the port.
    assign grant_l = l_req & (~c_req | ~last_owner);

    always_comb begin
        state_d      = state;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner;
        c_cap        = 1'b0;
        l_cap        = 1'b0;
        case (state)
            S_IDLE: begin
                if (c_req | l_req) begin
                    owner_d = grant_l;
                    we_d    = grant_l ? l_we    : c_we;
                    addr_d  = grant_l ? l_addr  : c_addr;
                    wdata_d = grant_l ? l_wdata : c_wdata;
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    c_cap        = ~we_q & ~owner_q;
                    l_cap        = ~we_q & owner_q;
                    last_owner_d = owner_q;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            last_owner <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            c_rdata    <= '0;
            l_rdata    <= '0;
        end else begin
            state      <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            last_owner <= last_owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if (c_cap) c_rdata <= m_rdata;
            if (l_cap) l_rdata <= m_rdata;
        end
    end

    assign m_rd_en   = (state == S_ACCESS) & ~we_q;
    assign m_wr_en   = (state == S_ACCESS) & we_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign c_done    = (state == S_RESP) & ~owner_q;
    assign l_done    = (state == S_RESP) & owner_q;
    assign busy      = (state != S_IDLE);
    assign owner     = owner_q;
    assign cpu_stall = c_req & ~c_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances with MEM_LAT = 1, 2, 3 share data inputs but have private requests.
// Completions are checked by a scoreboard monitor against expectations queued when each request is driven.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        c_req [3];
    logic        l_req [3];
    logic        c_we = 1'b0, l_we = 1'b0;
    logic [31:0] c_addr = '0, l_addr = '0, c_wdata = '0, l_wdata = '0, m_rdata = '0;

    logic [31:0] c_rdata [3];
    logic [31:0] l_rdata [3];
    logic [31:0] m_addr  [3];
    logic [31:0] m_wdata [3];
    logic        c_done [3], l_done [3], cpu_stall [3], m_rd_en [3], m_wr_en [3], busy [3], owner [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1)) u_dut (
            .clk(clk), .rst(rst),
            .c_req(c_req[g]), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
            .c_rdata(c_rdata[g]), .c_done(c_done[g]), .cpu_stall(cpu_stall[g]),
            .l_req(l_req[g]), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
            .l_rdata(l_rdata[g]), .l_done(l_done[g]),
            .m_rd_en(m_rd_en[g]), .m_wr_en(m_wr_en[g]), .m_addr(m_addr[g]),
            .m_wdata(m_wdata[g]), .m_rdata(m_rdata),
            .busy(busy[g]), .owner(owner[g])
        );
    end

    typedef struct {
        int          dut;
        bit          port;
        bit          we;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        int          dut;
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
    } vec_t;

    exp_t        sb [$];
    logic [31:0] mdl [3][2];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse must match the oldest queued transaction.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            if (c_done[g] || l_done[g]) begin
                chk("done_exclusive", 64'(c_done[g] & l_done[g]), 64'(0));
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("sb_who", 64'({e.dut, e.port}), 64'({g, l_done[g]}));
                    if (!e.we) mdl[g][e.port] = e.rd;
                    chk("sb_c_rdata", 64'(c_rdata[g]), 64'(mdl[g][0]));
                    chk("sb_l_rdata", 64'(l_rdata[g]), 64'(mdl[g][1]));
                end
            end
        end
    end

    task automatic drive_port(input int g, input bit port, input bit we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (!port) begin
            c_we = we; c_addr = addr; c_wdata = wdata; c_req[g] = 1'b1;
        end else begin
            l_we = we; l_addr = addr; l_wdata = wdata; l_req[g] = 1'b1;
        end
    endtask

    task automatic run_txn(input vec_t v);
        int   lat;
        exp_t e;
        lat     = v.dut + 1;
        m_rdata = v.rd;
        drive_port(v.dut, v.port, v.we, v.addr, v.wdata);
        e = '{v.dut, v.port, v.we, v.rd};
        sb.push_back(e);
        #1;
        chk("stall_cycle0", 64'(cpu_stall[v.dut]), 64'(!v.port));
        for (int k = 1; k <= lat + 1; k++) begin
            step();
            if (k <= lat) begin
                chk("strobe_addr", 64'({m_rd_en[v.dut], m_wr_en[v.dut], m_addr[v.dut]}),
                    64'({~v.we, v.we, v.addr}));
                if (v.we) chk("strobe_wdata", 64'(m_wdata[v.dut]), 64'(v.wdata));
                chk("busy_owner", 64'({busy[v.dut], owner[v.dut]}), 64'({1'b1, v.port}));
                chk("stall_access", 64'(cpu_stall[v.dut]), 64'(!v.port));
            end else begin
                chk("done_cycle", 64'({c_done[v.dut], l_done[v.dut], m_rd_en[v.dut], m_wr_en[v.dut], busy[v.dut]}),
                    64'({!v.port, v.port, 1'b0, 1'b0, 1'b1}));
                chk("stall_done", 64'(cpu_stall[v.dut]), 64'(0));
            end
        end
        step();
        c_req[v.dut] = 1'b0;
        l_req[v.dut] = 1'b0;
        chk("idle_after", 64'(busy[v.dut]), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [9];
        exp_t e;

        for (int g = 0; g < 3; g++) begin
            c_req[g] = 1'b0;
            l_req[g] = 1'b0;
            mdl[g][0] = '0;
            mdl[g][1] = '0;
        end

        vecs[0] = '{0, 1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{0, 1'b1, 1'b1, 32'h20, 32'h12345678, 32'hFFFF0000};
        vecs[2] = '{0, 1'b1, 1'b0, 32'h24, 32'h0,        32'hA5A50001};
        vecs[3] = '{0, 1'b0, 1'b1, 32'h30, 32'hCAFE0030, 32'h99999999};
        vecs[4] = '{2, 1'b0, 1'b0, 32'h40, 32'h0,        32'hCAFEF00D};
        vecs[5] = '{1, 1'b1, 1'b1, 32'h50, 32'h00005050, 32'h77770000};
        vecs[6] = '{1, 1'b0, 1'b0, 32'h54, 32'h0,        32'h0BADF00D};
        vecs[7] = '{2, 1'b1, 1'b0, 32'h58, 32'h0,        32'h13579BDF};
        vecs[8] = '{2, 1'b0, 1'b1, 32'h5C, 32'h2468ACE0, 32'h55555555};

        #12;
        for (int g = 0; g < 3; g++) begin
            chk("reset_ctrl", 64'({c_done[g], l_done[g], m_rd_en[g], m_wr_en[g], busy[g], owner[g], cpu_stall[g]}), 64'(0));
            chk("reset_rdata", {c_rdata[g], l_rdata[g]}, 64'(0));
        end
        step();
        rst = 1'b1;

        // Both requesters held on the MEM_LAT=1 instance: C first, then strict alternation.
        m_rdata = 32'h600DCAFE;
        c_we = 1'b0; c_addr = 32'h100;
        l_we = 1'b0; l_addr = 32'h200;
        c_req[0] = 1'b1;
        l_req[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = '{0, bit'(i % 2), 1'b0, 32'h600DCAFE};
            sb.push_back(e);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("rr_done", 64'({c_done[0], l_done[0]}), 64'({k == 2 || k == 8, k == 5 || k == 11}));
            if (k == 11) begin
                c_req[0] = 1'b0;
                l_req[0] = 1'b0;
            end
        end
        chk("rr_idle", 64'(busy[0]), 64'(0));

        for (int i = 0; i < 9; i++) run_txn(vecs[i]);

        // Reset asserted mid-access on the MEM_LAT=3 instance.
        m_rdata = 32'h77777777;
        drive_port(2, 1'b0, 1'b0, 32'h70, 32'h0);
        step();
        step();
        chk("pre_reset_access", 64'({busy[2], m_rd_en[2]}), 64'({1'b1, 1'b1}));
        #3;
        rst = 1'b0;
        c_req[2] = 1'b0;
        #1;
        chk("async_reset_ctrl", 64'({c_done[2], l_done[2], m_rd_en[2], m_wr_en[2], busy[2], owner[2]}), 64'(0));
        chk("async_reset_rdata", {c_rdata[2], l_rdata[2]}, 64'(0));
        for (int g = 0; g < 3; g++) begin
            mdl[g][0] = '0;
            mdl[g][1] = '0;
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk("in_reset_quiet", 64'({c_done[2], l_done[2], busy[2]}), 64'(0));
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_reset_quiet", 64'({c_done[2], l_done[2], busy[2]}), 64'(0));
        end

        // Tie right after reset goes to C; L follows once C drops its request.
        m_rdata = 32'h31415926;
        drive_port(2, 1'b0, 1'b0, 32'h90, 32'h0);
        drive_port(2, 1'b1, 1'b1, 32'h94, 32'hFEEDFACE);
        e = '{2, 1'b0, 1'b0, 32'h31415926}; sb.push_back(e);
        e = '{2, 1'b1, 1'b1, 32'h31415926}; sb.push_back(e);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) chk("tie_owner", 64'({busy[2], owner[2]}), 64'({1'b1, 1'b0}));
            if (k == 6) chk("tie_owner_l", 64'({busy[2], owner[2], m_wr_en[2], m_wdata[2]}),
                            64'({1'b1, 1'b1, 1'b1, 32'hFEEDFACE}));
            chk("tie_done", 64'({c_done[2], l_done[2]}), 64'({k == 4, k == 9}));
            if (k == 4) c_req[2] = 1'b0;
            if (k == 9) l_req[2] = 1'b0;
        end

        // MEM_LAT=2 CPU write whose request drops in cycle 1; a loader read follows.
        m_rdata = 32'h5A5A1234;
        drive_port(1, 1'b0, 1'b1, 32'h80, 32'hAAAA5555);
        l_we = 1'b0; l_addr = 32'h84;
        e = '{1, 1'b0, 1'b1, 32'h5A5A1234}; sb.push_back(e);
        e = '{1, 1'b1, 1'b0, 32'h5A5A1234}; sb.push_back(e);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("drop_seq", 64'({m_wr_en[1], m_rd_en[1], c_done[1], l_done[1]}),
                64'({k == 1 || k == 2, k == 5 || k == 6, k == 3, k == 7}));
            if (k == 1) begin
                c_req[1] = 1'b0;
                l_req[1] = 1'b1;
            end
            if (k == 7) l_req[1] = 1'b0;
        end

        step();
        step();
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
